// File: rtl/bus_receiver.sv
// bus_receiver: sink side of the shared tri-state data bus.
// Captures one word per cycle while the active driver's enable is high,
// buffers the words in a small FIFO with a registered head, hands them to
// the local consumer over valid/ready, and flags overflow and an idle bus.
module bus_receiver #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int IDLE_MAX = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_en,
  input  logic [WIDTH-1:0]           bus_data,
  output logic                       bus_ready,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       idle_timeout
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int CountW = $clog2(DEPTH+1);
  localparam logic [CountW-1:0] FullCount = CountW'(DEPTH);
  localparam logic [CountW-1:0] OneCount  = CountW'(1);
  localparam logic [7:0]        IdleLimit = 8'(IDLE_MAX);

  typedef enum logic {
    ACTIVE,
    IDLE
  } IdleState_e;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CountW-1:0] count_q, count_d;
  logic [WIDTH-1:0]  rdData_q, rdData_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        idleCnt_q, idleCnt_d;
  IdleState_e        state_q, state_d;

  logic fifoFull;
  logic fifoValid;
  logic doPush;
  logic doPop;

  // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
  // that is being read can still take the incoming word.
  always_comb begin
    fifoFull  = (count_q == FullCount);
    fifoValid = (count_q != '0);
    doPop     = fifoValid && rd_ready;
    doPush    = bus_en && (!fifoFull || doPop);
  end

  // Next-state for pointers, occupancy, head register and sticky overflow.
  always_comb begin
    wrPtr_d    = wrPtr_q + PtrW'(doPush);
    rdPtr_d    = rdPtr_q + PtrW'(doPop);
    count_d    = count_q;
    rdData_d   = rdData_q;
    overflow_d = overflow_q;

    case ({doPush, doPop})
      2'b10:   count_d = count_q + OneCount;
      2'b01:   count_d = count_q - OneCount;
      default: count_d = count_q;
    endcase

    // The head comes from storage when older words remain after a pop;
    // it comes straight from the bus when the new word becomes the oldest.
    if (doPop && (count_q > OneCount)) begin
      rdData_d = mem_q[rdPtr_d];
    end else if (doPush && (!fifoValid || doPop)) begin
      rdData_d = bus_data;
    end

    if (bus_en && fifoFull && !doPop) begin
      overflow_d = 1'b1;
    end
  end

  // Storage array: written only on an accepted word, so idle bus values
  // never reach the buffer.
  always_ff @(posedge clk) begin
    if (doPush && !reset) begin
      mem_q[wrPtr_q] <= bus_data;
    end
  end

  // FIFO control registers; reset drops every buffered word at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      rdData_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      rdData_q   <= rdData_d;
      overflow_q <= overflow_d;
    end
  end

  // Idle tracker next-state: count quiet cycles up to the limit, any bus
  // activity returns to ACTIVE with a cleared counter.
  always_comb begin
    idleCnt_d = idleCnt_q;
    state_d   = state_q;
    if (bus_en) begin
      idleCnt_d = 8'd0;
      state_d   = ACTIVE;
    end else begin
      if (idleCnt_q < IdleLimit) begin
        idleCnt_d = idleCnt_q + 8'd1;
      end
      if (idleCnt_d == IdleLimit) begin
        state_d = IDLE;
      end
    end
  end

  // Idle tracker state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idleCnt_q <= 8'd0;
      state_q   <= ACTIVE;
    end else begin
      idleCnt_q <= idleCnt_d;
      state_q   <= state_d;
    end
  end

  assign bus_ready    = !fifoFull || doPop;
  assign rd_valid     = fifoValid;
  assign rd_data      = rdData_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign idle_timeout = (state_q == IDLE);

endmodule

// File: tb/tb_bus_receiver.sv
// tb_bus_receiver: scenario tasks for bus_receiver plus a scoreboard that
// queues every accepted bus word and checks it when the consumer takes it.
module tb_bus_receiver;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int IDLE_MAX = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             bus_en;
  logic [WIDTH-1:0] bus_data;
  logic             bus_ready;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [2:0]       count;
  logic             overflow;
  logic             idle_timeout;

  int assertCount = 0;
  int failCount   = 0;

  logic [WIDTH-1:0] expQ [$];
  int               idleModel;
  bit               ovfModel;
  bit               mPop, mFull, mPush;

  bus_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_MAX(IDLE_MAX)) dut (
    .clk(clk),
    .reset(reset),
    .bus_en(bus_en),
    .bus_data(bus_data),
    .bus_ready(bus_ready),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .count(count),
    .overflow(overflow),
    .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are stable mid-cycle, so the falling edge decides what
  // the coming rising edge will push and pop, and checks the DUT state.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      ovfModel  = 1'b0;
      idleModel = 0;
    end else begin
      mFull = (expQ.size() == DEPTH);
      mPop  = (expQ.size() != 0) && rd_ready;
      mPush = bus_en && (!mFull || mPop);

      assertCount++;
      if (count !== 3'(expQ.size())) begin
        failCount++;
        $display("[TB] FAIL sb_count: got %0d expected %0d", count, expQ.size());
      end
      assertCount++;
      if (rd_valid !== (expQ.size() != 0)) begin
        failCount++;
        $display("[TB] FAIL sb_rd_valid: got %b expected %b", rd_valid, expQ.size() != 0);
      end
      assertCount++;
      if (bus_ready !== (!mFull || mPop)) begin
        failCount++;
        $display("[TB] FAIL sb_bus_ready: got %b expected %b", bus_ready, !mFull || mPop);
      end
      assertCount++;
      if (overflow !== ovfModel) begin
        failCount++;
        $display("[TB] FAIL sb_overflow: got %b expected %b", overflow, ovfModel);
      end
      assertCount++;
      if (idle_timeout !== (idleModel >= IDLE_MAX)) begin
        failCount++;
        $display("[TB] FAIL sb_idle_timeout: got %b expected %b", idle_timeout, idleModel >= IDLE_MAX);
      end
      if (expQ.size() != 0) begin
        assertCount++;
        if (rd_data !== expQ[0]) begin
          failCount++;
          $display("[TB] FAIL sb_rd_data: got %h expected %h", rd_data, expQ[0]);
        end
      end

      if (mPop) void'(expQ.pop_front());
      if (mPush) expQ.push_back(bus_data);
      if (bus_en && mFull && !mPop) ovfModel = 1'b1;
      if (bus_en) idleModel = 0;
      else if (idleModel < IDLE_MAX) idleModel++;
    end
  end

  // Drive one cycle of inputs and return just after the rising edge.
  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] data, input logic rdy);
    bus_en   = en;
    bus_data = data;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset    = 1'b1;
    bus_en   = 1'b0;
    rd_ready = 1'b0;
    bus_data = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    doReset();
    assertCount++;
    if (count !== 3'd0) begin failCount++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    assertCount++;
    if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    assertCount++;
    if (rd_data !== 8'h00) begin failCount++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
    assertCount++;
    if (bus_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_bus_ready: got %b expected 1", bus_ready); end
    assertCount++;
    if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    assertCount++;
    if (idle_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL reset_idle: got %b expected 0", idle_timeout); end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hxx, 1'b0);
    assertCount++;
    if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL xbus_rd_valid: got %b expected 0", rd_valid); end
    assertCount++;
    if (count !== 3'd0) begin failCount++; $display("[TB] FAIL xbus_count: got %0d expected 0", count); end
    assertCount++;
    if ($isunknown(rd_data)) begin failCount++; $display("[TB] FAIL xbus_rd_data: got %h expected known value", rd_data); end
  endtask

  task automatic test_two_words;
    applyStimulus(1'b1, 8'h55, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    bus_en = 1'b0;
    assertCount++;
    if (count !== 3'd2) begin failCount++; $display("[TB] FAIL two_count: got %0d expected 2", count); end
    assertCount++;
    if (rd_data !== 8'h55) begin failCount++; $display("[TB] FAIL two_first: got %h expected 55", rd_data); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    assertCount++;
    if (rd_data !== 8'hAA) begin failCount++; $display("[TB] FAIL two_second: got %h expected aa", rd_data); end
    applyStimulus(1'b0, 8'h00, 1'b1);
    assertCount++;
    if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL two_drained: got %b expected 0", rd_valid); end
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow;
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    assertCount++;
    if (count !== 3'd4) begin failCount++; $display("[TB] FAIL ovf_count: got %0d expected 4", count); end
    assertCount++;
    if (bus_ready !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_bus_ready: got %b expected 0", bus_ready); end
    assertCount++;
    if (overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      assertCount++;
      if (rd_data !== 8'(i)) begin failCount++; $display("[TB] FAIL ovf_read: got %h expected %h", rd_data, 8'(i)); end
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    assertCount++;
    if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_drained: got %b expected 0", rd_valid); end
    assertCount++;
    if (overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    rd_ready = 1'b0;
  endtask

  task automatic test_full_pop;
    logic [WIDTH-1:0] expOrder [4];
    expOrder = '{8'hA1, 8'hA2, 8'hA3, 8'h10};
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
    bus_en   = 1'b1;
    bus_data = 8'h10;
    rd_ready = 1'b1;
    #1;
    assertCount++;
    if (bus_ready !== 1'b1) begin failCount++; $display("[TB] FAIL fullpop_bus_ready: got %b expected 1", bus_ready); end
    @(posedge clk);
    #1;
    assertCount++;
    if (count !== 3'd4) begin failCount++; $display("[TB] FAIL fullpop_count: got %0d expected 4", count); end
    assertCount++;
    if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (rd_data !== expOrder[i]) begin failCount++; $display("[TB] FAIL fullpop_read: got %h expected %h", rd_data, expOrder[i]); end
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_idle;
    doReset();
    for (int i = 1; i <= IDLE_MAX + 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      assertCount++;
      if (idle_timeout !== (i >= IDLE_MAX)) begin
        failCount++;
        $display("[TB] FAIL idle_cycle%0d: got %b expected %b", i, idle_timeout, i >= IDLE_MAX);
      end
    end
    applyStimulus(1'b1, 8'h77, 1'b0);
    assertCount++;
    if (idle_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL idle_clear: got %b expected 0", idle_timeout); end
    applyStimulus(1'b0, 8'h00, 1'b0);
    assertCount++;
    if (idle_timeout !== 1'b0) begin failCount++; $display("[TB] FAIL idle_restart: got %b expected 0", idle_timeout); end
  endtask

  task automatic test_reset_mid;
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    rd_ready = 1'b0;
    assertCount++;
    if (count !== 3'd3) begin failCount++; $display("[TB] FAIL mid_pre_count: got %0d expected 3", count); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    assertCount++;
    if (count !== 3'd0) begin failCount++; $display("[TB] FAIL mid_count: got %0d expected 0", count); end
    assertCount++;
    if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL mid_rd_valid: got %b expected 0", rd_valid); end
    assertCount++;
    if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL mid_overflow: got %b expected 0", overflow); end
    assertCount++;
    if (bus_ready !== 1'b1) begin failCount++; $display("[TB] FAIL mid_bus_ready: got %b expected 1", bus_ready); end
    assertCount++;
    if (rd_data !== 8'h00) begin failCount++; $display("[TB] FAIL mid_rd_data: got %h expected 00", rd_data); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] word;
    doReset();
    for (int i = 0; i < 8; i++) begin
      word = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, word, 1'b1);
      assertCount++;
      if (count !== 3'd1) begin failCount++; $display("[TB] FAIL b2b_count: got %0d expected 1", count); end
      assertCount++;
      if (rd_data !== word) begin failCount++; $display("[TB] FAIL b2b_data: got %h expected %h", rd_data, word); end
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    assertCount++;
    if (rd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_drained: got %b expected 0", rd_valid); end
    rd_ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    bus_en   = 1'b0;
    rd_ready = 1'b0;
    bus_data = '0;
    test_reset();
    test_two_words();
    test_overflow();
    test_full_pop();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
